// File: rtl/half_subtractor_if.sv
// Bundle for the lane-parallel half subtractor: operand/valid inputs and
// registered results plus the borrow event counter.
interface half_subtractor_if #(
    parameter int WIDTH = 1,
    parameter int CNT_W = 16
);
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             in_valid;
    logic             count_clr;
    logic [WIDTH-1:0] difference;
    logic [WIDTH-1:0] borrow;
    logic             out_valid;
    logic [CNT_W-1:0] borrow_count;

    modport master (
        output a, b, in_valid, count_clr,
        input  difference, borrow, out_valid, borrow_count
    );

    modport slave (
        input  a, b, in_valid, count_clr,
        output difference, borrow, out_valid, borrow_count
    );
endinterface

// File: rtl/half_subtractor.sv
// Registered, lane-parallel half subtractor with a saturating counter of
// accepted samples that produced any borrow.
module half_subtractor_lane (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic a,
    input  logic b,
    output logic difference,
    output logic borrow,
    output logic borrow_nxt
);
    assign borrow_nxt = ~a & b;

    always_ff @(posedge clk) begin
        if (rst) begin
            difference <= 1'b0;
            borrow     <= 1'b0;
        end else if (en) begin
            difference <= a ^ b;
            borrow     <= borrow_nxt;
        end
    end
endmodule

module half_subtractor #(
    parameter int WIDTH = 1,
    parameter int CNT_W = 16
) (
    input logic             clk,
    input logic             rst,
    half_subtractor_if.slave bus
);
    logic [WIDTH-1:0] diff_q;
    logic [WIDTH-1:0] borr_q;
    logic [WIDTH-1:0] borr_nxt;
    logic             vld_q;
    logic [CNT_W-1:0] cnt_q;
    logic             borrow_evt;

    for (genvar i = 0; i < WIDTH; i++) begin : g_lane
        half_subtractor_lane u_lane (
            .clk        (clk),
            .rst        (rst),
            .en         (bus.in_valid),
            .a          (bus.a[i]),
            .b          (bus.b[i]),
            .difference (diff_q[i]),
            .borrow     (borr_q[i]),
            .borrow_nxt (borr_nxt[i])
        );
    end

    // Gate with in_valid first so unknown operands on idle cycles cannot leak in.
    assign borrow_evt = bus.in_valid && (|borr_nxt);

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q <= 1'b0;
            cnt_q <= '0;
        end else begin
            vld_q <= bus.in_valid;
            if (bus.count_clr)
                cnt_q <= '0;
            else if (borrow_evt && (cnt_q != '1))
                cnt_q <= cnt_q + 1'b1;
        end
    end

    assign bus.difference   = diff_q;
    assign bus.borrow       = borr_q;
    assign bus.out_valid    = vld_q;
    assign bus.borrow_count = cnt_q;
endmodule

// File: tb/tb_half_subtractor.sv
// Directed-vector bench: truth table, reset, hold, multi-lane, counter clear
// and saturation across three differently parameterized instances.
module tb_half_subtractor;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    half_subtractor_if #(.WIDTH(1), .CNT_W(16)) if1 ();
    half_subtractor_if #(.WIDTH(4), .CNT_W(16)) if4 ();
    half_subtractor_if #(.WIDTH(1), .CNT_W(2))  ifs ();

    half_subtractor #(.WIDTH(1), .CNT_W(16)) u_dut1 (.clk(clk), .rst(rst), .bus(if1));
    half_subtractor #(.WIDTH(4), .CNT_W(16)) u_dut4 (.clk(clk), .rst(rst), .bus(if4));
    half_subtractor #(.WIDTH(1), .CNT_W(2))  u_duts (.clk(clk), .rst(rst), .bus(ifs));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Check the single-lane instance: difference, borrow, out_valid, count.
    task automatic chk1(input string tag, input logic d, input logic br,
                        input logic ov, input logic [15:0] cnt);
        chk({tag, ".diff"},  32'(if1.difference),   32'(d));
        chk({tag, ".borr"},  32'(if1.borrow),       32'(br));
        chk({tag, ".ov"},    32'(if1.out_valid),    32'(ov));
        chk({tag, ".cnt"},   32'(if1.borrow_count), 32'(cnt));
    endtask

    // Truth table vectors: {a,b} and expected {difference,borrow}.
    logic [1:0] tt_in  [4] = '{2'b00, 2'b10, 2'b01, 2'b11};
    logic [1:0] tt_exp [4] = '{2'b00, 2'b10, 2'b11, 2'b00};

    initial begin
        if1.a = '0; if1.b = '0; if1.in_valid = 1'b0; if1.count_clr = 1'b0;
        if4.a = '0; if4.b = '0; if4.in_valid = 1'b0; if4.count_clr = 1'b0;
        ifs.a = '0; ifs.b = '0; ifs.in_valid = 1'b0; ifs.count_clr = 1'b0;

        // Reset held for 2 cycles with a borrowing sample presented
        rst = 1'b1;
        if1.in_valid = 1'b1; if1.a = 1'b0; if1.b = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            chk1("rst_hold", 1'b0, 1'b0, 1'b0, 16'd0);
        end
        rst = 1'b0;
        tick();
        chk1("rst_first", 1'b1, 1'b1, 1'b1, 16'd1);

        // Clear counter on an idle cycle
        if1.in_valid = 1'b0; if1.count_clr = 1'b1;
        tick();
        chk1("clr_idle", 1'b1, 1'b1, 1'b0, 16'd0);
        if1.count_clr = 1'b0;

        // Truth table, back to back
        for (int i = 0; i < 4; i++) begin
            if1.in_valid = 1'b1;
            if1.a = tt_in[i][1];
            if1.b = tt_in[i][0];
            tick();
            chk($sformatf("tt%0d.diff", i), 32'(if1.difference), 32'(tt_exp[i][1]));
            chk($sformatf("tt%0d.borr", i), 32'(if1.borrow),     32'(tt_exp[i][0]));
            chk($sformatf("tt%0d.ov", i),   32'(if1.out_valid),  32'd1);
        end
        chk("tt.cnt", 32'(if1.borrow_count), 32'd1);

        // Hold: accept 0,1 then idle 3 cycles with toggling/unknown operands
        if1.a = 1'b0; if1.b = 1'b1;
        tick();
        chk1("hold_acc", 1'b1, 1'b1, 1'b1, 16'd2);
        if1.in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if1.a = (i == 2) ? 1'bx : 1'(i);
            if1.b = (i == 2) ? 1'bx : ~1'(i);
            tick();
            chk1($sformatf("hold%0d", i), 1'b1, 1'b1, 1'b0, 16'd2);
        end

        // Clear wins over a simultaneous borrowing sample
        if1.in_valid = 1'b1; if1.a = 1'b0; if1.b = 1'b1; if1.count_clr = 1'b1;
        tick();
        chk1("clr_win", 1'b1, 1'b1, 1'b1, 16'd0);
        if1.count_clr = 1'b0;

        // Reset on the cycle after an accepted sample
        if1.a = 1'b1; if1.b = 1'b0;
        tick();
        chk1("mid_acc", 1'b1, 1'b0, 1'b1, 16'd0);
        if1.a = 1'b0; if1.b = 1'b1;
        tick();
        chk1("mid_acc2", 1'b1, 1'b1, 1'b1, 16'd1);
        rst = 1'b1;
        tick();
        chk1("mid_rst", 1'b0, 1'b0, 1'b0, 16'd0);
        rst = 1'b0;
        if1.in_valid = 1'b0;

        // Multi-lane: lanes independent, one count per borrowing sample
        if4.in_valid = 1'b1; if4.a = 4'b0101; if4.b = 4'b0011;
        tick();
        chk("ml0.diff", 32'(if4.difference),   32'h6);
        chk("ml0.borr", 32'(if4.borrow),       32'h2);
        chk("ml0.cnt",  32'(if4.borrow_count), 32'd1);
        if4.a = 4'b1111; if4.b = 4'b0000;
        tick();
        chk("ml1.diff", 32'(if4.difference),   32'hf);
        chk("ml1.borr", 32'(if4.borrow),       32'h0);
        chk("ml1.cnt",  32'(if4.borrow_count), 32'd1);
        if4.a = 4'b0000; if4.b = 4'b1111;
        tick();
        chk("ml2.diff", 32'(if4.difference),   32'hf);
        chk("ml2.borr", 32'(if4.borrow),       32'hf);
        chk("ml2.cnt",  32'(if4.borrow_count), 32'd2);
        if4.in_valid = 1'b0;
        tick();
        chk("ml3.ov",   32'(if4.out_valid),    32'd0);

        // Saturation with CNT_W=2
        ifs.in_valid = 1'b1; ifs.a = 1'b0; ifs.b = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk($sformatf("sat%0d.cnt", i), 32'(ifs.borrow_count), (i < 3) ? 32'(i + 1) : 32'd3);
        end
        ifs.in_valid = 1'b0; ifs.count_clr = 1'b1;
        tick();
        chk("sat_clr.cnt", 32'(ifs.borrow_count), 32'd0);
        ifs.count_clr = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/half_subtractor.md
# half_subtractor

Registered, lane-parallel half subtractor. Each lane computes difference = a XOR b and borrow = (NOT a) AND b for single-bit operands. Outputs are registered behind a valid qualifier, and a saturating counter tracks accepted samples that produced a borrow. It is the leaf arithmetic cell for the subtractor datapath and a unit-level check target for truth-table verification.

## Interface
- WIDTH, 1, number of independent 1-bit subtractor lanes (bit i of each vector is lane i).
- CNT_W, 16, width of the borrow event counter.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- a  input  WIDTH  minuend bits, one per lane.
- b  input  WIDTH  subtrahend bits, one per lane.
- in_valid  input  1  sample a/b on this cycle's rising edge when high.
- count_clr  input  1  synchronous clear of borrow_count.
- difference  output  WIDTH  registered a XOR b, per lane.
- borrow  output  WIDTH  registered (NOT a) AND b, per lane.
- out_valid  output  1  high for exactly one cycle after each accepted sample.
- borrow_count  output  CNT_W  number of accepted samples with any borrow bit set; saturating.

## Operation
- Per-lane function (a,b -> difference,borrow): 0,0->0,0; 1,0->1,0; 0,1->1,1; 1,1->0,0. Lanes are fully independent, with no borrow propagation between lanes.
- Accepted sample: rising edge with rst=0 and in_valid=1. On that edge:
  - difference and borrow are loaded from the current a and b.
  - out_valid is set to 1.
- When in_valid=0 and rst=0: difference and borrow hold their previous values, and out_valid is set to 0.
- borrow_count update, in priority order:
  - rst=1 -> 0.
  - Otherwise count_clr=1 -> 0. The clear wins over a simultaneous borrow event, and that event is not counted.
  - Otherwise, on an accepted sample where the borrow result is nonzero (any lane), increment by 1.
  - At all-ones (2^CNT_W-1) it holds and does not wrap.
- X/Z on a or b when in_valid=0 has no effect on state.

## Timing
- Latency is 1 cycle: a/b sampled at edge N appear on difference/borrow after edge N. out_valid is high during the cycle following edge N.
- Throughput is one sample per cycle. Back-to-back in_valid yields continuous out_valid, with the outputs updating every cycle.
- No backpressure: the consumer must take the result while out_valid=1. The data outputs remain stable until the next accepted sample.
- Reset values: difference=0, borrow=0, out_valid=0, borrow_count=0.
- Reset has priority over in_valid and count_clr on the same edge. A sample presented during reset is discarded.
- Reset mid-stream: the first edge with rst=1 forces all outputs to their reset values. The first sample is accepted on the first edge with rst=0 and in_valid=1.
- borrow_count reflects a sample on the same edge that its difference and borrow are loaded.

## Test plan
- Truth table (WIDTH=1): apply a,b = 00,10,01,11, each with in_valid=1 and held for one cycle.
  - Required difference,borrow one cycle later: 0,0 / 1,0 / 1,1 / 0,0.
  - out_valid is high for four consecutive cycles.
  - borrow_count ends at 1.
- Reset: with rst=1 for 2 cycles and in_valid=1, a=0, b=1, the outputs stay 0,0, out_valid=0 and borrow_count=0. After rst falls, the first edge yields 1,1.
- Hold: accept a=0, b=1, then drop in_valid for 3 cycles while toggling a and b.
  - difference=1 and borrow=1 are held throughout.
  - out_valid=0 for those 3 cycles.
- Multi-lane (WIDTH=4): a=4'b0101, b=4'b0011 -> difference=4'b0110, borrow=4'b0010, and borrow_count increments by exactly 1.
- Counter clear and saturation:
  - Assert count_clr together with a borrowing sample -> borrow_count=0.
  - With CNT_W=2, apply 5 consecutive borrowing samples -> borrow_count sticks at 3.
- Reset mid-stream: apply rst=1 on the cycle after an accepted sample -> difference, borrow, out_valid and borrow_count all read 0 on the next cycle.
